// File: rtl/seg_scan_if.sv
// seg_scan_if: scanned segment bus in, decoded time frame and status flags out.
interface seg_scan_if;
    logic [7:0] seg_in;
    logic [5:0] sel_in;
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic       frame_valid;
    logic       code_err;
    logic       dp_err;
    logic       range_err;
    logic       sel_err;
    logic       timeout;

    modport master (
        output seg_in, sel_in,
        input  hours, minutes, seconds, frame_valid, code_err, dp_err, range_err, sel_err, timeout
    );

    modport slave (
        input  seg_in, sel_in,
        output hours, minutes, seconds, frame_valid, code_err, dp_err, range_err, sel_err, timeout
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes a multiplexed 7-segment scan back into BCD hh:mm:ss frames.
// Define SEG_SCAN_RANGE_CHK_EN to build the time range check behind range_err.
module seg_scan_decoder #(
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 50000
) (
    input logic  clk,
    input logic  rst_n,
    seg_scan_if.slave bus
);
    localparam int SW = $clog2(STABLE_CYC) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [13:0]      prev;
    logic [SW-1:0]    scnt, scnt_nxt;
    logic [TW-1:0]    tcnt, tcnt_inc;
    logic [5:0]       mask;
    logic [5:0][3:0]  shadow;
    logic             code_stk, dp_stk;
    logic             same, one_hot, acc, pub, to_hit, bad_code, bad_dp, clr;
    logic [3:0]       nib;
    logic [2:0]       idx;

    function automatic logic [3:0] dec(input logic [6:0] p);
        case (p)
            7'h40:   dec = 4'd0;
            7'h79:   dec = 4'd1;
            7'h24:   dec = 4'd2;
            7'h30:   dec = 4'd3;
            7'h19:   dec = 4'd4;
            7'h12:   dec = 4'd5;
            7'h02:   dec = 4'd6;
            7'h78:   dec = 4'd7;
            7'h00:   dec = 4'd8;
            7'h10:   dec = 4'd9;
            default: dec = 4'hF;
        endcase
    endfunction

    always_comb begin
        same     = {bus.sel_in, bus.seg_in} == prev;
        one_hot  = (bus.sel_in != 6'd0) && ((bus.sel_in & (bus.sel_in - 6'd1)) == 6'd0);
        scnt_nxt = !same ? SW'(1) : (&scnt ? scnt : scnt + 1'b1);
        // the extra term stops a saturated count from re-accepting the same hold
        acc      = one_hot && scnt_nxt == SW'(STABLE_CYC) && (!same || scnt != SW'(STABLE_CYC));
        pub      = &mask;
        tcnt_inc = &tcnt ? tcnt : tcnt + 1'b1;
        to_hit   = !acc && !pub && (|mask) && tcnt_inc == TW'(TIMEOUT);
        clr      = pub || to_hit;
        nib      = dec(bus.seg_in[6:0]);
        bad_code = nib == 4'hF;
        bad_dp   = bus.seg_in[7] != !(bus.sel_in[2] || bus.sel_in[4]);
        idx      = {bus.sel_in[4] | bus.sel_in[5], bus.sel_in[2] | bus.sel_in[3],
                    bus.sel_in[1] | bus.sel_in[3] | bus.sel_in[5]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev            <= '0;
            scnt            <= '0;
            tcnt            <= '0;
            mask            <= '0;
            shadow          <= '0;
            code_stk        <= 1'b0;
            dp_stk          <= 1'b0;
            bus.hours       <= 8'h00;
            bus.minutes     <= 8'h00;
            bus.seconds     <= 8'h00;
            bus.code_err    <= 1'b0;
            bus.dp_err      <= 1'b0;
            bus.frame_valid <= 1'b0;
            bus.sel_err     <= 1'b0;
            bus.timeout     <= 1'b0;
        end else begin
            prev            <= {bus.sel_in, bus.seg_in};
            scnt            <= scnt_nxt;
            tcnt            <= (acc || pub) ? '0 : tcnt_inc;
            bus.sel_err     <= bus.sel_in != prev[13:8] && (|bus.sel_in) && !one_hot;
            bus.frame_valid <= pub;
            bus.timeout     <= to_hit;
            // an accept on the clearing edge starts the next frame
            mask            <= (clr ? 6'd0 : mask) | (acc ? bus.sel_in : 6'd0);
            code_stk        <= (!clr && code_stk) || (acc && bad_code);
            dp_stk          <= (!clr && dp_stk) || (acc && bad_dp);
            if (acc) shadow[idx] <= nib;
            if (pub) begin
                bus.hours    <= {shadow[5], shadow[4]};
                bus.minutes  <= {shadow[3], shadow[2]};
                bus.seconds  <= {shadow[1], shadow[0]};
                bus.code_err <= code_stk;
                bus.dp_err   <= dp_stk;
            end
        end
    end

`ifdef SEG_SCAN_RANGE_CHK_EN
    logic rng;

    always_comb
        rng = shadow[1] > 4'd5 || shadow[3] > 4'd5 || shadow[0] > 4'd9 || shadow[2] > 4'd9 ||
              shadow[4] > 4'd9 || {shadow[5], shadow[4]} > 8'h23;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.range_err <= 1'b0;
        else if (pub) bus.range_err <= rng;
    end
`else
    assign bus.range_err = 1'b0;
`endif
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans with a frame scoreboard for seg_scan_decoder.
module tb_seg_scan_decoder;
    localparam int TO = 200;
`ifdef SEG_SCAN_RANGE_CHK_EN
    localparam logic RNG_ON = 1'b1;
`else
    localparam logic RNG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   fv_cnt = 0;
    int   sel_err_cnt = 0;
    int   to_cnt = 0;
    logic [26:0] sb[$];
    logic [6:0]  pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg_scan_if bus ();

    seg_scan_decoder #(.STABLE_CYC(4), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] enc(input logic [3:0] d, input int pos);
        return {!(pos == 2 || pos == 4), pat[d]};
    endfunction

    function automatic logic rng(input logic [23:0] t);
        return RNG_ON && (t[7:4] > 4'd5 || t[15:12] > 4'd5 || t[3:0] > 4'd9 || t[11:8] > 4'd9 ||
                          t[19:16] > 4'd9 || t[23:16] > 8'h23);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [5:0] s, input logic [7:0] g, input int n);
        bus.sel_in = s;
        bus.seg_in = g;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [23:0] t, input int lo, input int hi);
        for (int p = lo; p <= hi; p++) hold(6'(1 << p), enc(t[p*4 +: 4], p), 8);
    endtask

    task automatic expect_frame(input logic [23:0] t, input logic c, input logic d);
        sb.push_back({t, c, d, rng(t)});
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
        chk("frame_arrival", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.sel_err) sel_err_cnt++;
            if (bus.timeout) to_cnt++;
            if (bus.frame_valid) begin
                fv_cnt++;
                tests++;
                assert (sb.size() > 0) else begin
                    fails++;
                    $error("FAIL unexpected_frame got %h%h%h expected none", bus.hours, bus.minutes, bus.seconds);
                end
                if (sb.size() > 0) begin
                    logic [26:0] exp;
                    logic [26:0] obs;
                    exp = sb.pop_front();
                    obs = {bus.hours, bus.minutes, bus.seconds, bus.code_err, bus.dp_err, bus.range_err};
                    tests++;
                    assert (obs === exp) else begin
                        fails++;
                        $error("FAIL frame got %h expected %h", obs, exp);
                    end
                end
            end
        end
    end

    initial begin
        int f, se, t0;
        bus.sel_in = 6'd0;
        bus.seg_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_time", {bus.hours, bus.minutes, bus.seconds}, 0);
        chk("rst_flags", {bus.frame_valid, bus.code_err, bus.dp_err, bus.range_err, bus.sel_err, bus.timeout}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        expect_frame(24'h123456, 1'b0, 1'b0);
        scan(24'h123456, 0, 5);
        settle();
        chk("clean_hours", bus.hours, 8'h12);

        expect_frame(24'h123456, 1'b0, 1'b1);
        scan(24'h123456, 0, 3);
        hold(6'b010000, 8'hA4, 8);
        scan(24'h123456, 5, 5);
        settle();
        chk("dp_err_hold", bus.dp_err, 1'b1);

        expect_frame(24'h12345F, 1'b1, 1'b0);
        hold(6'b000001, 8'hFF, 8);
        scan(24'h123456, 1, 5);
        settle();
        chk("blank_seconds", bus.seconds, 8'h5F);

        expect_frame(24'h123456, 1'b0, 1'b0);
        scan(24'h123456, 0, 5);
        settle();
        chk("code_err_clears", bus.code_err, 1'b0);

        f  = fv_cnt;
        se = sel_err_cnt;
        hold(6'b000001, enc(4'd9, 0), 3);
        hold(6'b000011, enc(4'd9, 0), 1);
        scan(24'h654321, 1, 5);
        repeat (5) @(posedge clk);
        #1;
        chk("no_short_accept", fv_cnt, f);
        chk("sel_err_once", sel_err_cnt, se + 1);
        expect_frame(24'h654321, 1'b0, 1'b0);
        scan(24'h654321, 0, 0);
        settle();
        chk("seconds_after_short", bus.seconds, 8'h21);

        f  = fv_cnt;
        t0 = to_cnt;
        scan(24'h111111, 0, 2);
        bus.sel_in = 6'd0;
        bus.seg_in = 8'hFF;
        for (int i = 0; i < TO + 50 && to_cnt == t0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("timeout_pulse", to_cnt, t0 + 1);
        chk("no_frame_on_timeout", fv_cnt, f);
        chk("hold_after_timeout", bus.minutes, 8'h43);
        expect_frame(24'h235959, 1'b0, 1'b0);
        scan(24'h235959, 0, 5);
        settle();

        expect_frame(24'h256100, 1'b0, 1'b0);
        scan(24'h256100, 0, 5);
        settle();
        chk("range_err", bus.range_err, RNG_ON);

        scan(24'h999999, 0, 2);
        rst_n = 1'b0;
        #2;
        chk("midrst_time", {bus.hours, bus.minutes, bus.seconds}, 0);
        chk("midrst_flags", {bus.code_err, bus.dp_err, bus.range_err}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_frame(24'h010203, 1'b0, 1'b0);
        scan(24'h010203, 0, 5);
        settle();
        chk("post_rst_hours", bus.hours, 8'h01);

        chk("frame_total", fv_cnt, 8);
        chk("timeout_total", to_cnt, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
